ctrl_seq_p: RTL and testbench
=============================

# ctrl_seq_p

Parametrised successor to the CPU control sequencer. It fetches instructions over the instruction-memory handshake, decodes the 5-bit opcode, and drives PC, ACC, IN and INDR enables plus the datapath selects. Unlike the previous sequencer it:

- uses a dedicated MEM_WAIT state for data-memory access;
- has a configurable data width;
- enforces a per-handshake wait-state timeout with a sticky FAULT state;
- gates all strobes with HOLDn.

It sits between the APB instruction/data memory bridges and the datapath.

## Interface
- DATA_W, 16: instruction word width; OPERAND is DATA_W-5 bits; must be at least 8.
- TIMEOUT, 15: maximum cycles waiting on READY_INST/READY_DATA; 0 disables the timeout.
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- HOLDn  in  1  0 freezes state, INST and the wait counter.
- DATA  in  DATA_W  instruction word from instruction memory.
- ZN  in  2  flags: Z=ZN[1], N=ZN[0].
- READY_INST, READY_DATA  in  1 each  memory ready.
- CLR_FAULT  in  1  leaves FAULT.
- OPCODE  out  5  INST[DATA_W-1:DATA_W-5].
- OPERAND  out  DATA_W-5  INST[DATA_W-6:0].
- SEL_JMP, SEL_BRANCH, SEL_OP_MEM  out  1 each  active-low selects; default 1.
- WRITE, EN_APB_INST_MEM, EN_APB_DATA_MEM  out  1 each.
- en_PC, en_ACC, en_IN, EN_INDR, SEL_INDR  out  1 each.
- FAULT  out  1  high in FAULT state.
- state_out  out  3  current state encoding.

## Operation
- State encodings: IDLE=0, PRE_FET=1, FETCH=2, DECODE=3, EXECUTE=4, MEM_WAIT=5, FAULT=6. Unused codes go to IDLE.
- Opcode classes:
  - CF: JMP 01110, BEQ 01000, BNE 01001, BGT 01010, BGE 01011, BLT 01100, BLE 01101.
  - LDC: LD 00010, ADD 00100, SUB 00110, AND 10000, OR 10010, XOR 10100, LDV 11001.
  - STC: STO 00001, STOV 11000.
  - INDRWR: 11101.
  - Any other opcode is a NOP.
- Outputs are Moore/opcode-decoded combinational. Every output not listed below holds its default: selects 1, all others 0.
- IDLE: EN_APB_INST_MEM=1. Next state PRE_FET.
- PRE_FET: next state FETCH.
- FETCH: on READY_INST, INST<=DATA, en_PC=1, next state DECODE. Otherwise stay in FETCH.
- DECODE (one cycle):
  - en_IN=1.
  - JMP: SEL_JMP=0, en_PC=1.
  - Branches: en_PC=1, SEL_BRANCH=0 when the condition holds. BEQ Z; BNE !Z; BGT !Z&&!N; BGE !N; BLT N; BLE Z||N.
  - INDRWR: EN_INDR=1.
  - Next state: CF → IDLE; LDC or STC → MEM_WAIT; otherwise → EXECUTE.
- MEM_WAIT:
  - EN_APB_DATA_MEM=1.
  - LDC: SEL_OP_MEM=0.
  - STC: WRITE=1.
  - LDV/STOV: SEL_INDR=1; EN_INDR=1 in the READY_DATA cycle.
  - On READY_DATA → EXECUTE.
- EXECUTE:
  - EN_APB_INST_MEM=1.
  - en_ACC=1 only for LDC, so stores and NOPs no longer clobber ACC.
  - LDV/STOV: SEL_INDR=1.
  - Next state PRE_FET.
- FAULT: FAULT=1, all other outputs at default. Stays in FAULT until CLR_FAULT=1, then → IDLE. CLR_FAULT is ignored in every other state.
- Timeout counter (width $clog2(TIMEOUT+1)):
  - Cleared on entry to FETCH or MEM_WAIT.
  - Increments each unheld cycle spent there without ready.
  - When the count reaches TIMEOUT-1 with ready still low, the next state is FAULT.
  - Ready arriving in the limit cycle wins, and the normal transition is taken.
- HOLDn=0: state, INST and the counter hold. en_PC, en_ACC, en_IN, EN_INDR and WRITE are forced 0. Selects and the EN_APB_* outputs keep their decoded values.

## Timing
- Reset (RESET high, asynchronous):
  - state=IDLE, INST=0, counter=0.
  - Outputs: EN_APB_INST_MEM=1, selects 1, all other outputs 0, OPCODE=0, state_out=0.
- Reset mid-transaction aborts it immediately. No WRITE pulse survives reset.
- Non-memory instruction: IDLE→PRE_FET→FETCH(READY)→DECODE→EXECUTE→PRE_FET. Minimum 4 cycles per instruction after the first.
- CF instruction: FETCH→DECODE→IDLE. The PC update occurs in the DECODE cycle.
- Memory instruction: one more cycle than a non-memory instruction, plus the number of READY_DATA wait cycles.
- TIMEOUT=N: FAULT is entered on the edge after N consecutive not-ready cycles.

## Structure
- Shared package ctrl_pkg: opcode localparams, state encodings, and class-decode functions (is_cf, is_ldc, is_stc, is_indr, branch_taken).
- Sub-module ctrl_wait_timer: clear / count-enable / expired for the timeout counter; it is the only natural split.

## Test plan
- RESET pulse mid-MEM_WAIT of STO → state_out=0, WRITE=0, EN_APB_INST_MEM=1 asynchronously; INST=0.
- ADD 0x2005 with READY_DATA after 2 cycles → SEL_OP_MEM=0 for 3 MEM_WAIT cycles, en_ACC=1 for one EXECUTE cycle, OPERAND=0x005.
- BEQ with ZN=2'b10, then ZN=2'b00 → en_PC and SEL_BRANCH=0 in DECODE for the first only; both go DECODE→IDLE.
- STOV with TIMEOUT=3 and READY_DATA never asserted → WRITE=1 for 3 cycles, then FAULT=1, state_out=6. CLR_FAULT → IDLE.
- HOLDn=0 for 5 cycles during DECODE of JMP → state_out stays 3, en_PC=0, SEL_JMP=0. After release, one en_PC pulse.
- DATA_W=24, STO 0x080123 → OPERAND=19'h00123, no en_ACC in EXECUTE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcodes and
// instruction-class decode helpers.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPreFet  = 3'd1,
        StFetch   = 3'd2,
        StDecode  = 3'd3,
        StExecute = 3'd4,
        StMemWait = 3'd5,
        StFault   = 3'd6
    } state_e;

    localparam logic [4:0] OpSto    = 5'b00001;
    localparam logic [4:0] OpLd     = 5'b00010;
    localparam logic [4:0] OpAdd    = 5'b00100;
    localparam logic [4:0] OpSub    = 5'b00110;
    localparam logic [4:0] OpBeq    = 5'b01000;
    localparam logic [4:0] OpBne    = 5'b01001;
    localparam logic [4:0] OpBgt    = 5'b01010;
    localparam logic [4:0] OpBge    = 5'b01011;
    localparam logic [4:0] OpBlt    = 5'b01100;
    localparam logic [4:0] OpBle    = 5'b01101;
    localparam logic [4:0] OpJmp    = 5'b01110;
    localparam logic [4:0] OpAnd    = 5'b10000;
    localparam logic [4:0] OpOr     = 5'b10010;
    localparam logic [4:0] OpXor    = 5'b10100;
    localparam logic [4:0] OpStov   = 5'b11000;
    localparam logic [4:0] OpLdv    = 5'b11001;
    localparam logic [4:0] OpIndrWr = 5'b11101;

    // Timer width never drops to zero, even with the timeout disabled.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = (limit == 0) ? 1 : $clog2(limit + 1);
        return w;
    endfunction

    function automatic logic is_cf(input logic [4:0] op);
        return op inside {OpJmp, OpBeq, OpBne, OpBgt, OpBge, OpBlt, OpBle};
    endfunction

    function automatic logic is_ldc(input logic [4:0] op);
        return op inside {OpLd, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpLdv};
    endfunction

    function automatic logic is_stc(input logic [4:0] op);
        return op inside {OpSto, OpStov};
    endfunction

    // Indirect memory access through INDR.
    function automatic logic is_indr(input logic [4:0] op);
        return op inside {OpLdv, OpStov};
    endfunction

    function automatic logic branch_taken(input logic [4:0] op, input logic [1:0] zn);
        logic z;
        logic n;
        logic taken;
        z = zn[1];
        n = zn[0];
        case (op)
            OpBeq:   taken = z;
            OpBne:   taken = ~z;
            OpBgt:   taken = ~z & ~n;
            OpBge:   taken = ~n;
            OpBlt:   taken = n;
            OpBle:   taken = z | n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_seq_p_if.sv
// Handshake and datapath-control bundle between the sequencer (master) and its
// memory bridges / datapath (slave).
interface ctrl_seq_p_if #(
    parameter int unsigned DataW = 16
);
    logic             hold_n;
    logic [DataW-1:0] data;
    logic [1:0]       zn;
    logic             ready_inst;
    logic             ready_data;
    logic             clr_fault;

    logic [4:0]       opcode;
    logic [DataW-6:0] operand;
    logic             sel_jmp;
    logic             sel_branch;
    logic             sel_op_mem;
    logic             write;
    logic             en_apb_inst_mem;
    logic             en_apb_data_mem;
    logic             en_pc;
    logic             en_acc;
    logic             en_in;
    logic             en_indr;
    logic             sel_indr;
    logic             fault;
    logic [2:0]       state_out;

    modport master (
        input  hold_n, data, zn, ready_inst, ready_data, clr_fault,
        output opcode, operand, sel_jmp, sel_branch, sel_op_mem, write,
               en_apb_inst_mem, en_apb_data_mem, en_pc, en_acc, en_in, en_indr,
               sel_indr, fault, state_out
    );

    modport slave (
        output hold_n, data, zn, ready_inst, ready_data, clr_fault,
        input  opcode, operand, sel_jmp, sel_branch, sel_op_mem, write,
               en_apb_inst_mem, en_apb_data_mem, en_pc, en_acc, en_in, en_indr,
               sel_indr, fault, state_out
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Wait-state counter for memory handshakes; flags the last allowed not-ready cycle.
module ctrl_wait_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned Timeout = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);
    localparam int unsigned CntW = cnt_width(Timeout);
    localparam logic [CntW-1:0] Limit = CntW'((Timeout == 0) ? 0 : Timeout - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (Timeout != 0) && (cnt_q == Limit);
endmodule

// File: rtl/ctrl_seq_p.sv
// CPU control sequencer: fetch/decode/memory/execute FSM with wait-state timeout,
// sticky fault state and HOLDn strobe gating.
module ctrl_seq_p
    import ctrl_pkg::*;
#(
    parameter int unsigned DataW   = 16,
    parameter int unsigned Timeout = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ctrl_seq_p_if.master  bus
);
    state_e           state_q, state_d;
    logic [DataW-1:0] inst_q, inst_d;
    logic [4:0]       op;

    logic in_wait, ready, tmr_expired;
    logic sel_jmp, sel_branch, sel_op_mem, write, apb_inst, apb_data;
    logic en_pc, en_acc, en_in, en_indr, sel_indr, fault;

    assign op      = inst_q[DataW-1 -: 5];
    assign in_wait = (state_q == StFetch) || (state_q == StMemWait);
    assign ready   = (state_q == StFetch) ? bus.ready_inst : bus.ready_data;

    // Counter sits at zero outside the wait states, so each wait starts fresh.
    ctrl_wait_timer #(
        .Timeout (Timeout)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (~in_wait),
        .count_i   (bus.hold_n & in_wait & ~ready),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        sel_jmp    = 1'b1;
        sel_branch = 1'b1;
        sel_op_mem = 1'b1;
        write      = 1'b0;
        apb_inst   = 1'b0;
        apb_data   = 1'b0;
        en_pc      = 1'b0;
        en_acc     = 1'b0;
        en_in      = 1'b0;
        en_indr    = 1'b0;
        sel_indr   = 1'b0;
        fault      = 1'b0;

        case (state_q)
            StIdle: begin
                apb_inst = 1'b1;
                state_d  = StPreFet;
            end
            StPreFet: state_d = StFetch;
            StFetch: begin
                if (bus.ready_inst) begin
                    en_pc   = 1'b1;
                    inst_d  = bus.data;
                    state_d = StDecode;
                end else if (tmr_expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                en_in = 1'b1;
                if (op == OpJmp) begin
                    sel_jmp = 1'b0;
                    en_pc   = 1'b1;
                end else if (branch_taken(op, bus.zn)) begin
                    sel_branch = 1'b0;
                    en_pc      = 1'b1;
                end
                en_indr = (op == OpIndrWr);
                if (is_cf(op)) begin
                    state_d = StIdle;
                end else if (is_ldc(op) || is_stc(op)) begin
                    state_d = StMemWait;
                end else begin
                    state_d = StExecute;
                end
            end
            StMemWait: begin
                apb_data   = 1'b1;
                sel_op_mem = ~is_ldc(op);
                write      = is_stc(op);
                sel_indr   = is_indr(op);
                en_indr    = is_indr(op) & bus.ready_data;
                if (bus.ready_data) begin
                    state_d = StExecute;
                end else if (tmr_expired) begin
                    state_d = StFault;
                end
            end
            StExecute: begin
                apb_inst = 1'b1;
                en_acc   = is_ldc(op);
                sel_indr = is_indr(op);
                state_d  = StPreFet;
            end
            StFault: begin
                fault = 1'b1;
                if (bus.clr_fault) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Hold freezes state and INST; register-write strobes drop, selects stay.
        if (!bus.hold_n) begin
            state_d = state_q;
            inst_d  = inst_q;
            en_pc   = 1'b0;
            en_acc  = 1'b0;
            en_in   = 1'b0;
            en_indr = 1'b0;
            write   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.opcode          = op;
    assign bus.operand         = inst_q[DataW-6:0];
    assign bus.sel_jmp         = sel_jmp;
    assign bus.sel_branch      = sel_branch;
    assign bus.sel_op_mem      = sel_op_mem;
    assign bus.write           = write;
    assign bus.en_apb_inst_mem = apb_inst;
    assign bus.en_apb_data_mem = apb_data;
    assign bus.en_pc           = en_pc;
    assign bus.en_acc          = en_acc;
    assign bus.en_in           = en_in;
    assign bus.en_indr         = en_indr;
    assign bus.sel_indr        = sel_indr;
    assign bus.fault           = fault;
    assign bus.state_out       = state_q;
endmodule

// File: tb/tb_ctrl_seq_p.sv
// Bench for ctrl_seq_p: two instances (16-bit/TIMEOUT=3 and 24-bit/TIMEOUT=15) run in
// lockstep against a per-instruction phase model.
module tb_ctrl_seq_p;
    typedef struct packed {
        logic [2:0] st;
        logic fault, apbi, apbd, wr, sj, sb, sm, si, pc, acc, in, indr;
    } exp_t;

    localparam logic [4:0] STO = 5'b00001, ADD = 5'b00100, BEQ = 5'b01000, JMP = 5'b01110;
    localparam logic [4:0] STOV = 5'b11000, LDV = 5'b11001, INDRWR = 5'b11101, NOP = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_n = 1'b1;
    logic [1:0] zn = 2'b00;
    logic ri = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [15:0] data_a = '0;
    logic [23:0] data_b = '0;
    int n_checks = 0;
    int n_errs = 0;
    bit only_a = 1'b0;
    bit at_idle = 1'b1;

    always #5 clk = ~clk;

    ctrl_seq_p_if #(.DataW(16)) if_a ();
    ctrl_seq_p_if #(.DataW(24)) if_b ();

    assign if_a.hold_n = hold_n;  assign if_b.hold_n = hold_n;
    assign if_a.zn = zn;          assign if_b.zn = zn;
    assign if_a.ready_inst = ri;  assign if_b.ready_inst = ri;
    assign if_a.ready_data = rd;  assign if_b.ready_data = rd;
    assign if_a.clr_fault = clr;  assign if_b.clr_fault = clr;
    assign if_a.data = data_a;    assign if_b.data = data_b;

    ctrl_seq_p #(.DataW(16), .Timeout(3)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
    ctrl_seq_p #(.DataW(24), .Timeout(15)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

    exp_t obs_a, obs_b;
    assign obs_a = {if_a.state_out, if_a.fault, if_a.en_apb_inst_mem, if_a.en_apb_data_mem,
                    if_a.write, if_a.sel_jmp, if_a.sel_branch, if_a.sel_op_mem, if_a.sel_indr,
                    if_a.en_pc, if_a.en_acc, if_a.en_in, if_a.en_indr};
    assign obs_b = {if_b.state_out, if_b.fault, if_b.en_apb_inst_mem, if_b.en_apb_data_mem,
                    if_b.write, if_b.sel_jmp, if_b.sel_branch, if_b.sel_op_mem, if_b.sel_indr,
                    if_b.en_pc, if_b.en_acc, if_b.en_in, if_b.en_indr};

    function automatic bit c_cf(input logic [4:0] op);
        return op inside {5'b01110, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101};
    endfunction
    function automatic bit c_ld(input logic [4:0] op);
        return op inside {5'b00010, 5'b00100, 5'b00110, 5'b10000, 5'b10010, 5'b10100, 5'b11001};
    endfunction
    function automatic bit c_st(input logic [4:0] op);
        return op inside {5'b00001, 5'b11000};
    endfunction
    function automatic bit c_ind(input logic [4:0] op);
        return (op == LDV) || (op == STOV);
    endfunction

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.sj = 1'b1;
        e.sb = 1'b1;
        e.sm = 1'b1;
        return e;
    endfunction

    task automatic chk_now(input string tag, input exp_t e);
        n_checks++;
        assert (obs_a === e) else begin
            n_errs++;
            $error("FAIL %s dut_a: got %h want %h", tag, obs_a, e);
        end
        if (!only_a) begin
            n_checks++;
            assert (obs_b === e) else begin
                n_errs++;
                $error("FAIL %s dut_b: got %h want %h", tag, obs_b, e);
            end
        end
    endtask

    // Settle, compare, then move to one time unit past the next rising edge.
    task automatic chk(input string tag, input exp_t e);
        #1;
        chk_now(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_inst(input string tag, input logic [4:0] op, input logic [18:0] opnd);
        n_checks++;
        assert (if_a.opcode === op && if_a.operand === opnd[10:0]) else begin
            n_errs++;
            $error("FAIL %s dut_a: got %h/%h want %h/%h", tag, if_a.opcode, if_a.operand,
                   op, opnd[10:0]);
        end
        if (!only_a) begin
            n_checks++;
            assert (if_b.opcode === op && if_b.operand === opnd) else begin
                n_errs++;
                $error("FAIL %s dut_b: got %h/%h want %h/%h", tag, if_b.opcode, if_b.operand,
                       op, opnd);
            end
        end
    endtask

    task automatic t_idle();
        exp_t e;
        e = base(3'd0);
        e.apbi = 1'b1;
        chk("idle", e);
    endtask

    task automatic t_fetch(input logic [4:0] op, input logic [18:0] opnd, input int waits);
        exp_t e;
        chk("prefet", base(3'd1));
        ri = 1'b0;
        for (int i = 0; i < waits; i++) begin
            data_a = 16'($urandom);
            data_b = 24'($urandom);
            chk("fetch_wait", base(3'd2));
        end
        ri = 1'b1;
        data_a = {op, opnd[10:0]};
        data_b = {op, opnd};
        e = base(3'd2);
        e.pc = 1'b1;
        chk("fetch_ready", e);
        ri = 1'b0;
        data_a = 16'($urandom);
        data_b = 24'($urandom);
    endtask

    task automatic t_decode(input logic [4:0] op, input logic [18:0] opnd,
                            input logic [1:0] flags, input int holds);
        exp_t e, eh;
        bit z, n, take;
        zn = flags;
        z = flags[1];
        n = flags[0];
        case (op)
            5'b01000: take = z;
            5'b01001: take = !z;
            5'b01010: take = !z && !n;
            5'b01011: take = !n;
            5'b01100: take = n;
            5'b01101: take = z || n;
            default:  take = 1'b0;
        endcase
        e = base(3'd3);
        e.in = 1'b1;
        if (op == JMP) begin e.sj = 1'b0; e.pc = 1'b1; end
        if (take) begin e.sb = 1'b0; e.pc = 1'b1; end
        if (op == INDRWR) e.indr = 1'b1;
        #1;
        chk_inst("decode_inst", op, opnd);
        for (int i = 0; i < holds; i++) begin
            hold_n = 1'b0;
            eh = e;
            eh.pc = 1'b0;
            eh.in = 1'b0;
            eh.indr = 1'b0;
            chk("decode_hold", eh);
        end
        hold_n = 1'b1;
        chk("decode", e);
        zn = 2'($urandom);
    endtask

    task automatic t_mem(input logic [4:0] op, input int waits);
        exp_t e;
        e = base(3'd5);
        e.apbd = 1'b1;
        e.sm = !c_ld(op);
        e.wr = c_st(op);
        e.si = c_ind(op);
        rd = 1'b0;
        for (int i = 0; i < waits; i++) chk("mem_wait", e);
        rd = 1'b1;
        e.indr = c_ind(op);
        chk("mem_ready", e);
        rd = 1'b0;
    endtask

    task automatic t_exec(input logic [4:0] op);
        exp_t e;
        e = base(3'd4);
        e.apbi = 1'b1;
        e.acc = c_ld(op);
        e.si = c_ind(op);
        chk("execute", e);
    endtask

    task automatic do_instr(input logic [4:0] op, input logic [18:0] opnd,
                            input logic [1:0] flags, input int iw, input int dw, input int holds);
        if (at_idle) t_idle();
        t_fetch(op, opnd, iw);
        t_decode(op, opnd, flags, holds);
        if (c_cf(op)) begin
            at_idle = 1'b1;
        end else begin
            if (c_ld(op) || c_st(op)) t_mem(op, dw);
            t_exec(op);
            at_idle = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        // Reset state, applied from time zero.
        #1;
        e = base(3'd0);
        e.apbi = 1'b1;
        chk_now("reset", e);
        chk_inst("reset_inst", 5'd0, 19'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_instr(ADD, 19'h00005, 2'b00, 0, 2, 0);
        do_instr(BEQ, 19'h00011, 2'b10, 1, 0, 0);
        do_instr(BEQ, 19'h00022, 2'b00, 0, 0, 0);
        do_instr(JMP, 19'h00033, 2'b01, 0, 0, 5);
        clr = 1'b1;
        do_instr(STO, 19'h00123, 2'b00, 0, 1, 0);
        clr = 1'b0;
        do_instr(LDV, 19'h04567, 2'b11, 2, 1, 1);
        do_instr(INDRWR, 19'h00077, 2'b00, 0, 0, 2);
        do_instr(STOV, 19'h7ffff, 2'b01, 0, 2, 0);
        do_instr(NOP, 19'h00001, 2'b00, 1, 0, 0);

        for (int k = 0; k < 30; k++) begin
            do_instr(5'($urandom), 19'($urandom), 2'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a store's memory wait.
        if (at_idle) t_idle();
        t_fetch(STO, 19'h00042, 0);
        t_decode(STO, 19'h00042, 2'b00, 0);
        rd = 1'b0;
        e = base(3'd5);
        e.apbd = 1'b1;
        e.wr = 1'b1;
        chk("sto_mem", e);
        rst = 1'b1;
        #1;
        e = base(3'd0);
        e.apbi = 1'b1;
        chk_now("reset_mid_mem", e);
        chk_inst("reset_mid_inst", 5'd0, 19'd0);
        #1;
        rst = 1'b0;
        at_idle = 1'b1;
        do_instr(ADD, 19'h00abc, 2'b00, 0, 0, 0);

        // Store timeout on the TIMEOUT=3 instance, then clear the fault.
        only_a = 1'b1;
        if (at_idle) t_idle();
        t_fetch(STOV, 19'h00009, 0);
        t_decode(STOV, 19'h00009, 2'b00, 0);
        rd = 1'b0;
        e = base(3'd5);
        e.apbd = 1'b1;
        e.wr = 1'b1;
        e.si = 1'b1;
        for (int i = 0; i < 3; i++) chk("stov_timeout_wait", e);
        e = base(3'd6);
        e.fault = 1'b1;
        chk("fault", e);
        chk("fault_sticky", e);
        clr = 1'b1;
        chk("fault_clear", e);
        clr = 1'b0;
        t_idle();

        // Resynchronise both instances.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        only_a = 1'b0;
        at_idle = 1'b1;
        do_instr(ADD, 19'h00100, 2'b00, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
